// File: rtl/pll_reconfig_seq.sv
// PLL dynamic-reconfiguration sequencer: latches one M/K/C0 set, issues the fixed
// eight-write management sequence, pulses the PLL reset and waits for lock.
module pll_reconfig_seq #(
    parameter int unsigned GAP          = 7,
    parameter int unsigned RST_CYCLES   = 8,
    parameter int unsigned LOCK_TIMEOUT = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] m_val,
    input  logic [31:0] k_val,
    input  logic [31:0] c0_val,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [5:0]  mgmt_address,
    output logic [31:0] mgmt_writedata,
    output logic        mgmt_write,
    input  logic        mgmt_waitrequest,
    output logic        pll_reset,
    input  logic        locked
);

    localparam int unsigned CntMax = (GAP > RST_CYCLES) ? GAP : RST_CYCLES;
    localparam int unsigned CW     = $clog2(CntMax + 1);
    localparam int unsigned LW     = $clog2(LOCK_TIMEOUT + 1);

    typedef enum logic [2:0] {StIdle, StWrite, StGap, StRst, StLock} state_e;

    state_e          state_q, state_d;
    logic [2:0]      idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [LW-1:0]   lock_cnt_q, lock_cnt_d;
    logic            restart_q, restart_d;
    logic [31:0]     m_q, m_d, k_q, k_d, c0_q, c0_d;
    logic            busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic            wr_q, wr_d, pll_rst_q, pll_rst_d;
    logic [5:0]      addr_q, addr_d;
    logic [31:0]     data_q, data_d;
    logic            launch, go_next;
    logic [2:0]      launch_idx;

    function automatic logic [5:0] wr_addr(input logic [2:0] i);
        case (i)
            3'd0:    wr_addr = 6'd0;
            3'd1:    wr_addr = 6'd4;
            3'd2:    wr_addr = 6'd7;
            3'd3:    wr_addr = 6'd3;
            3'd4:    wr_addr = 6'd5;
            3'd5:    wr_addr = 6'd9;
            3'd6:    wr_addr = 6'd8;
            default: wr_addr = 6'd2;
        endcase
    endfunction

    function automatic logic [31:0] wr_data(input logic [2:0] i, input logic [31:0] m,
                                            input logic [31:0] k, input logic [31:0] c0);
        case (i)
            3'd1:    wr_data = m;
            3'd2:    wr_data = k;
            3'd3:    wr_data = 32'h0001_0000;
            3'd4:    wr_data = c0;
            3'd5:    wr_data = 32'd1;
            3'd6:    wr_data = 32'd7;
            default: wr_data = 32'd0;
        endcase
    endfunction

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        lock_cnt_d = lock_cnt_q;
        restart_d  = restart_q;
        m_d        = m_q;
        k_d        = k_q;
        c0_d       = c0_q;
        done_d     = 1'b0;
        error_d    = 1'b0;
        wr_d       = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        pll_rst_d  = 1'b0;
        launch     = 1'b0;
        launch_idx = 3'd0;
        go_next    = 1'b0;

        if (start) begin
            m_d  = m_val;
            k_d  = k_val;
            c0_d = c0_val;
        end

        case (state_q)
            StIdle: begin
                if (start) launch = 1'b1;
            end
            StWrite: begin
                wr_d = 1'b1;
                if (!mgmt_waitrequest) begin
                    wr_d = 1'b0;
                    if (start || restart_q) launch = 1'b1;
                    else if (GAP == 0) go_next = 1'b1;
                    else begin
                        state_d = StGap;
                        cnt_d   = CW'(GAP - 1);
                    end
                end else if (start) begin
                    // Stalled write must finish its handshake before the restart.
                    restart_d = 1'b1;
                end
            end
            StGap: begin
                if (start) launch = 1'b1;
                else if (cnt_q == '0) go_next = 1'b1;
                else cnt_d = cnt_q - 1'b1;
            end
            StRst: begin
                if (start) launch = 1'b1;
                else if (cnt_q == '0) begin
                    state_d    = StLock;
                    lock_cnt_d = '0;
                end else begin
                    pll_rst_d = 1'b1;
                    cnt_d     = cnt_q - 1'b1;
                end
            end
            StLock: begin
                if (start) launch = 1'b1;
                else if (locked) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else if (lock_cnt_q == LW'(LOCK_TIMEOUT - 1)) begin
                    error_d = 1'b1;
                    state_d = StIdle;
                end else begin
                    lock_cnt_d = lock_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (go_next) begin
            if (idx_q == 3'd7) begin
                state_d   = StRst;
                pll_rst_d = 1'b1;
                cnt_d     = CW'(RST_CYCLES - 1);
            end else begin
                launch     = 1'b1;
                launch_idx = idx_q + 3'd1;
            end
        end

        if (launch) begin
            state_d   = StWrite;
            idx_d     = launch_idx;
            wr_d      = 1'b1;
            addr_d    = wr_addr(launch_idx);
            data_d    = wr_data(launch_idx, m_d, k_d, c0_d);
            restart_d = 1'b0;
        end

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            cnt_q      <= '0;
            lock_cnt_q <= '0;
            restart_q  <= 1'b0;
            m_q        <= '0;
            k_q        <= '0;
            c0_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            pll_rst_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            lock_cnt_q <= lock_cnt_d;
            restart_q  <= restart_d;
            m_q        <= m_d;
            k_q        <= k_d;
            c0_q       <= c0_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            pll_rst_q  <= pll_rst_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;
    assign mgmt_write     = wr_q;
    assign mgmt_address   = addr_q;
    assign mgmt_writedata = data_q;
    assign pll_reset      = pll_rst_q;

endmodule
